// File: rtl/excp_flush_ctrl.sv
// ============================================================================
// Module      : excp_flush_ctrl
// Description : Flushes the pipeline and redirects the PC when WB commits an exception or ERTN.
//               Optional statistics counters are built when EXCP_FLUSH_STAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module excp_flush_ctrl #(
    parameter int OUTSTD_W   = 2,
    parameter int MAX_OUTSTD = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic        wb_ex,
    input  logic        wb_ertn,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    input  logic        inst_req_fire,
    input  logic        inst_resp,
    input  logic        if_redirect_rdy,
    output logic        flush,
    output logic        fetch_block,
    output logic        resp_discard,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] stat_ex_cnt,
    output logic [31:0] stat_ertn_cnt,
    output logic [31:0] stat_drop_cnt
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DRAIN    = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    localparam logic [OUTSTD_W-1:0] C_MAX  = OUTSTD_W'(MAX_OUTSTD);
    localparam logic [OUTSTD_W-1:0] C_ONE  = OUTSTD_W'(1);
    localparam logic [OUTSTD_W-1:0] C_ZERO = '0;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [OUTSTD_W-1:0] r_outstd;
    logic [OUTSTD_W-1:0] r_dcnt;
    logic [OUTSTD_W-1:0] w_outstd_calc;
    logic [31:0]         r_target;
    logic                w_trig;
    logic                w_idle;
    logic                w_drain;
    logic                w_redirect;

    assign w_trig     = wb_valid & (wb_ex | wb_ertn);
    assign w_idle     = (r_state == ST_IDLE);
    assign w_drain    = (r_state == ST_DRAIN);
    assign w_redirect = (r_state == ST_REDIRECT);

    // Outstanding count including this cycle's traffic, saturated at both ends.
    always_comb begin
        w_outstd_calc = r_outstd;
        if (inst_req_fire && !inst_resp) begin
            if (r_outstd != C_MAX) begin
                w_outstd_calc = r_outstd + C_ONE;
            end
        end else if (!inst_req_fire && inst_resp) begin
            if (r_outstd != C_ZERO) begin
                w_outstd_calc = r_outstd - C_ONE;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_trig) begin
                    w_state_nxt = (w_outstd_calc != C_ZERO) ? ST_DRAIN : ST_REDIRECT;
                end
            end
            ST_DRAIN: begin
                if (r_dcnt == C_ZERO || (inst_resp && r_dcnt == C_ONE)) begin
                    w_state_nxt = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (if_redirect_rdy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_outstd <= '0;
            r_dcnt   <= '0;
            r_target <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_idle) begin
                if (w_trig) begin
                    r_target <= wb_ex ? csr_eentry : csr_era;
                    r_dcnt   <= w_outstd_calc;
                    r_outstd <= '0;
                end else begin
                    r_outstd <= w_outstd_calc;
                end
            end else if (w_drain && inst_resp && r_dcnt != C_ZERO) begin
                r_dcnt <= r_dcnt - C_ONE;
            end
        end
    end

    assign flush          = w_idle & w_trig;
    assign fetch_block    = ~w_idle;
    assign resp_discard   = w_drain & inst_resp;
    assign redirect_valid = w_redirect;
    assign redirect_pc    = w_redirect ? r_target : 32'd0;

`ifdef EXCP_FLUSH_STAT_EN
    logic [31:0] r_ex_cnt;
    logic [31:0] r_ertn_cnt;
    logic [31:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_cnt   <= '0;
            r_ertn_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_idle && w_trig && wb_ex) begin
                r_ex_cnt <= r_ex_cnt + 32'd1;
            end
            if (w_idle && w_trig && !wb_ex) begin
                r_ertn_cnt <= r_ertn_cnt + 32'd1;
            end
            if (resp_discard) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
        end
    end

    assign stat_ex_cnt   = r_ex_cnt;
    assign stat_ertn_cnt = r_ertn_cnt;
    assign stat_drop_cnt = r_drop_cnt;
`else
    assign stat_ex_cnt   = 32'd0;
    assign stat_ertn_cnt = 32'd0;
    assign stat_drop_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_excp_flush_ctrl.sv
// ============================================================================
// Module      : tb_excp_flush_ctrl
// Description : Directed self-checking bench for excp_flush_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_excp_flush_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic        wb_ex;
    logic        wb_ertn;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    logic        inst_req_fire;
    logic        inst_resp;
    logic        if_redirect_rdy;
    logic        flush;
    logic        fetch_block;
    logic        resp_discard;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] stat_ex_cnt;
    logic [31:0] stat_ertn_cnt;
    logic [31:0] stat_drop_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_ex   = 0;
    int exp_ertn = 0;
    int exp_drop = 0;

    always #5 clk = ~clk;

    excp_flush_ctrl #(.OUTSTD_W(2), .MAX_OUTSTD(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .wb_valid        (wb_valid),
        .wb_ex           (wb_ex),
        .wb_ertn         (wb_ertn),
        .csr_eentry      (csr_eentry),
        .csr_era         (csr_era),
        .inst_req_fire   (inst_req_fire),
        .inst_resp       (inst_resp),
        .if_redirect_rdy (if_redirect_rdy),
        .flush           (flush),
        .fetch_block     (fetch_block),
        .resp_discard    (resp_discard),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stat_ex_cnt     (stat_ex_cnt),
        .stat_ertn_cnt   (stat_ertn_cnt),
        .stat_drop_cnt   (stat_drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_stats(input string tag);
`ifdef EXCP_FLUSH_STAT_EN
        chk({tag, "_ex"},   stat_ex_cnt,   32'(exp_ex));
        chk({tag, "_ertn"}, stat_ertn_cnt, 32'(exp_ertn));
        chk({tag, "_drop"}, stat_drop_cnt, 32'(exp_drop));
`else
        chk({tag, "_ex"},   stat_ex_cnt,   32'd0);
        chk({tag, "_ertn"}, stat_ertn_cnt, 32'd0);
        chk({tag, "_drop"}, stat_drop_cnt, 32'd0);
`endif
    endtask

    task automatic clear_wb();
        wb_valid = 1'b0;
        wb_ex    = 1'b0;
        wb_ertn  = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        clear_wb();
        csr_eentry      = 32'h1C00_8000;
        csr_era         = 32'h1C00_0100;
        inst_req_fire   = 1'b0;
        inst_resp       = 1'b0;
        if_redirect_rdy = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        settle();
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_block", {31'd0, fetch_block}, 32'd0);
        chk("rst_disc",  {31'd0, resp_discard}, 32'd0);
        chk("rst_rv",    {31'd0, redirect_valid}, 32'd0);
        chk("rst_pc",    redirect_pc, 32'd0);
        chk_stats("rst");

        // 1: exception with nothing outstanding -> redirect next cycle
        tick();
        wb_valid = 1'b1; wb_ex = 1'b1; csr_eentry = 32'h1C00_8000; csr_era = 32'hDEAD_0000;
        settle();
        chk("t1_flush", {31'd0, flush}, 32'd1);
        chk("t1_block0", {31'd0, fetch_block}, 32'd0);
        exp_ex++;
        tick();
        clear_wb();
        settle();
        chk("t1_flush_off", {31'd0, flush}, 32'd0);
        chk("t1_rv", {31'd0, redirect_valid}, 32'd1);
        chk("t1_pc", redirect_pc, 32'h1C00_8000);
        chk("t1_block", {31'd0, fetch_block}, 32'd1);
        if_redirect_rdy = 1'b1;
        tick();
        if_redirect_rdy = 1'b0;
        settle();
        chk("t1_idle_rv", {31'd0, redirect_valid}, 32'd0);
        chk("t1_idle_block", {31'd0, fetch_block}, 32'd0);

        // 2: two fetches in flight, ERTN drains both responses
        inst_req_fire = 1'b1;
        tick();
        tick();
        inst_req_fire = 1'b0;
        wb_valid = 1'b1; wb_ertn = 1'b1; csr_era = 32'h1C00_0100; csr_eentry = 32'hBEEF_0000;
        settle();
        chk("t2_flush", {31'd0, flush}, 32'd1);
        exp_ertn++;
        tick();
        clear_wb();
        settle();
        chk("t2_drain_block", {31'd0, fetch_block}, 32'd1);
        chk("t2_drain_rv", {31'd0, redirect_valid}, 32'd0);
        chk("t2_disc_idle", {31'd0, resp_discard}, 32'd0);
        inst_resp = 1'b1;
        settle();
        chk("t2_disc1", {31'd0, resp_discard}, 32'd1);
        exp_drop++;
        tick();
        settle();
        chk("t2_disc2", {31'd0, resp_discard}, 32'd1);
        chk("t2_rv_pending", {31'd0, redirect_valid}, 32'd0);
        exp_drop++;
        tick();
        settle();
        chk("t2_rv", {31'd0, redirect_valid}, 32'd1);
        chk("t2_pc", redirect_pc, 32'h1C00_0100);
        chk("t2_resp_in_redir", {31'd0, resp_discard}, 32'd0);
        inst_resp = 1'b0;
        if_redirect_rdy = 1'b1;
        tick();
        if_redirect_rdy = 1'b0;

        // 3: outstd=1, trigger cycle has both fire and resp -> one discard
        inst_req_fire = 1'b1;
        tick();
        wb_valid = 1'b1; wb_ex = 1'b1; csr_eentry = 32'h1C00_3000;
        inst_resp = 1'b1;
        settle();
        chk("t3_flush", {31'd0, flush}, 32'd1);
        chk("t3_no_disc_trig", {31'd0, resp_discard}, 32'd0);
        exp_ex++;
        tick();
        clear_wb();
        inst_req_fire = 1'b0;
        settle();
        chk("t3_disc", {31'd0, resp_discard}, 32'd1);
        chk("t3_rv_pending", {31'd0, redirect_valid}, 32'd0);
        exp_drop++;
        tick();
        settle();
        chk("t3_disc_done", {31'd0, resp_discard}, 32'd0);
        chk("t3_rv", {31'd0, redirect_valid}, 32'd1);
        chk("t3_pc", redirect_pc, 32'h1C00_3000);
        inst_resp = 1'b0;
        if_redirect_rdy = 1'b1;
        tick();
        if_redirect_rdy = 1'b0;

        // 4: wb_ex and wb_ertn together -> exception entry wins
        wb_valid = 1'b1; wb_ex = 1'b1; wb_ertn = 1'b1;
        csr_eentry = 32'h1C00_4444; csr_era = 32'h1C00_5555;
        exp_ex++;
        tick();
        clear_wb();
        settle();
        chk("t4_pc", redirect_pc, 32'h1C00_4444);
        if_redirect_rdy = 1'b1;
        tick();
        if_redirect_rdy = 1'b0;

        // 5: IF stalls the redirect for 5 cycles
        wb_valid = 1'b1; wb_ertn = 1'b1; csr_era = 32'h1C00_7770;
        exp_ertn++;
        tick();
        clear_wb();
        csr_era = 32'h0000_0000;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("t5_rv_%0d", i), {31'd0, redirect_valid}, 32'd1);
            chk($sformatf("t5_pc_%0d", i), redirect_pc, 32'h1C00_7770);
            chk($sformatf("t5_blk_%0d", i), {31'd0, fetch_block}, 32'd1);
            tick();
        end
        if_redirect_rdy = 1'b1;
        settle();
        chk("t5_rv_rdy", {31'd0, redirect_valid}, 32'd1);
        tick();
        if_redirect_rdy = 1'b0;
        settle();
        chk("t5_idle_block", {31'd0, fetch_block}, 32'd0);
        chk("t5_idle_rv", {31'd0, redirect_valid}, 32'd0);
        chk_stats("t5");

        // 6: reset in DRAIN clears everything
        inst_req_fire = 1'b1;
        tick();
        tick();
        inst_req_fire = 1'b0;
        wb_valid = 1'b1; wb_ex = 1'b1; csr_eentry = 32'h1C00_6000;
        exp_ex++;
        tick();
        clear_wb();
        settle();
        chk("t6_in_drain", {31'd0, fetch_block}, 32'd1);
        chk_stats("t6_pre");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_ex = 0; exp_ertn = 0; exp_drop = 0;
        settle();
        chk("t6_block", {31'd0, fetch_block}, 32'd0);
        chk("t6_rv", {31'd0, redirect_valid}, 32'd0);
        chk("t6_pc", redirect_pc, 32'd0);
        chk("t6_disc", {31'd0, resp_discard}, 32'd0);
        chk("t6_flush", {31'd0, flush}, 32'd0);
        chk_stats("t6_post");
        // outstanding count cleared: a new trigger redirects immediately
        wb_valid = 1'b1; wb_ertn = 1'b1; csr_era = 32'h1C00_0ABC;
        tick();
        clear_wb();
        settle();
        chk("t6_retrig_rv", {31'd0, redirect_valid}, 32'd1);
        chk("t6_retrig_pc", redirect_pc, 32'h1C00_0ABC);
        if_redirect_rdy = 1'b1;
        tick();
        if_redirect_rdy = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
